// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// Module   : uart_pkg
// Purpose  : Shared UART types, constants and parity helper (TX and RX).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

    localparam int DATA_BITS      = 8;
    localparam int OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    // par_ty = 1 selects even parity (bit = ^data), 0 selects odd (~^data).
    function automatic logic par_calc(input logic [DATA_BITS-1:0] data,
                                      input logic                 par_ty);
        return par_ty ? (^data) : (~^data);
    endfunction

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_if.sv
//------------------------------------------------------------------------------
// Module   : uart_rx_if
// Purpose  : Serial line, configuration and byte-delivery signals of uart_rx.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface uart_rx_if
    import uart_pkg::*;
();

    logic                 os_tick;
    logic                 rx;
    logic                 par_en;
    logic                 par_ty;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 parity_err;
    logic                 frame_err;
    logic                 rx_busy;

    // Line/configuration side: drives the serial input, consumes bytes.
    modport master (
        output os_tick, rx, par_en, par_ty,
        input  rx_data, rx_valid, parity_err, frame_err, rx_busy
    );

    // Receiver side.
    modport slave (
        input  os_tick, rx, par_en, par_ty,
        output rx_data, rx_valid, parity_err, frame_err, rx_busy
    );

endinterface : uart_rx_if

`default_nettype wire

// File: rtl/uart_sync.sv
//------------------------------------------------------------------------------
// Module   : uart_sync
// Purpose  : Multi-stage synchronizer for an idle-high asynchronous line.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_sync
);

    logic [SYNC_STAGES-1:0] r_stages;

    // Reset to 1 so a reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stages <= '1;
        end else begin
            r_stages <= {r_stages[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_stages[SYNC_STAGES-1];

endmodule : uart_sync

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// Module   : uart_rx
// Purpose  : Oversampling UART receiver, 8N1 / 8E1 / 8O1 with error flags.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int SYNC_STAGES = 2
) (
    input wire logic  clk,
    input wire logic  rst,
    uart_rx_if.slave  bus
);

    localparam int               TICK_W   = $clog2(OVERSAMPLE);
    localparam logic [TICK_W-1:0] MID_START = TICK_W'(OVERSAMPLE/2 - 1);
    localparam logic [TICK_W-1:0] MID_BIT   = TICK_W'(OVERSAMPLE - 1);
    localparam logic [2:0]        LAST_BIT  = 3'(DATA_BITS - 1);

    logic w_rx_s;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (bus.rx),
        .o_sync  (w_rx_s)
    );

    uart_state_t          r_state,      w_state;
    logic [TICK_W-1:0]    r_tick_cnt,   w_tick_cnt;
    logic [2:0]           r_bit_cnt,    w_bit_cnt;
    logic [DATA_BITS-1:0] r_shift,      w_shift;
    logic                 r_perr,       w_perr;
    logic                 r_armed,      w_armed;
    logic                 r_par_en,     w_par_en;
    logic                 r_par_ty,     w_par_ty;
    logic [DATA_BITS-1:0] r_rx_data,    w_rx_data;
    logic                 r_rx_valid,   w_rx_valid;
    logic                 r_parity_err, w_parity_err;
    logic                 r_frame_err,  w_frame_err;
    logic                 r_rx_busy,    w_rx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_armed      <= 1'b0;
            r_par_en     <= 1'b0;
            r_par_ty     <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
            r_rx_busy    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_tick_cnt   <= w_tick_cnt;
            r_bit_cnt    <= w_bit_cnt;
            r_shift      <= w_shift;
            r_perr       <= w_perr;
            r_armed      <= w_armed;
            r_par_en     <= w_par_en;
            r_par_ty     <= w_par_ty;
            r_rx_data    <= w_rx_data;
            r_rx_valid   <= w_rx_valid;
            r_parity_err <= w_parity_err;
            r_frame_err  <= w_frame_err;
            r_rx_busy    <= w_rx_busy;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_tick_cnt   = r_tick_cnt;
        w_bit_cnt    = r_bit_cnt;
        w_shift      = r_shift;
        w_perr       = r_perr;
        w_armed      = r_armed;
        w_par_en     = r_par_en;
        w_par_ty     = r_par_ty;
        w_rx_data    = r_rx_data;
        w_rx_valid   = 1'b0;
        w_parity_err = r_parity_err;
        w_frame_err  = r_frame_err;
        w_rx_busy    = r_rx_busy;

        if (bus.os_tick) begin
            case (r_state)
                IDLE: begin
                    // Only a high-to-low transition may open a frame.
                    if (w_rx_s) begin
                        w_armed = 1'b1;
                    end else if (r_armed) begin
                        w_state    = START;
                        w_tick_cnt = '0;
                        w_par_en   = bus.par_en;
                        w_par_ty   = bus.par_ty;
                    end
                end

                START: begin
                    if (r_tick_cnt == MID_START) begin
                        w_tick_cnt = '0;
                        if (!w_rx_s) begin
                            w_state   = DATA;
                            w_rx_busy = 1'b1;
                            w_bit_cnt = '0;
                        end else begin
                            w_state = IDLE;
                        end
                    end else begin
                        w_tick_cnt = r_tick_cnt + TICK_W'(1);
                    end
                end

                DATA: begin
                    if (r_tick_cnt == MID_BIT) begin
                        w_tick_cnt         = '0;
                        w_shift[r_bit_cnt] = w_rx_s;
                        if (r_bit_cnt == LAST_BIT) begin
                            w_perr  = 1'b0;
                            w_state = r_par_en ? PARITY : STOP;
                        end else begin
                            w_bit_cnt = r_bit_cnt + 3'd1;
                        end
                    end else begin
                        w_tick_cnt = r_tick_cnt + TICK_W'(1);
                    end
                end

                PARITY: begin
                    if (r_tick_cnt == MID_BIT) begin
                        w_tick_cnt = '0;
                        w_perr     = w_rx_s ^ par_calc(r_shift, r_par_ty);
                        w_state    = STOP;
                    end else begin
                        w_tick_cnt = r_tick_cnt + TICK_W'(1);
                    end
                end

                STOP: begin
                    // A low stop bit disarms until the line returns high.
                    if (r_tick_cnt == MID_BIT) begin
                        w_tick_cnt   = '0;
                        w_rx_data    = r_shift;
                        w_frame_err  = ~w_rx_s;
                        w_parity_err = r_perr;
                        w_rx_valid   = 1'b1;
                        w_rx_busy    = 1'b0;
                        w_armed      = w_rx_s;
                        w_state      = IDLE;
                    end else begin
                        w_tick_cnt = r_tick_cnt + TICK_W'(1);
                    end
                end

                default: begin
                    w_state = IDLE;
                end
            endcase
        end
    end

    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.rx_busy    = r_rx_busy;

endmodule : uart_rx

`default_nettype wire
